// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches op|dev|reg|data words from register_memory
// and turns them into I2C master transactions, halting with a code on fault.
module instruction_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       instr_data,
  input  logic [3:0]        mem_error,
  output logic              i2c_req_valid,
  input  logic              i2c_req_ready,
  output logic              i2c_req_rw,
  output logic [7:0]        i2c_dev_addr,
  output logic [7:0]        i2c_reg_addr,
  output logic [7:0]        i2c_wdata,
  input  logic              i2c_done,
  input  logic [7:0]        i2c_rdata,
  input  logic              i2c_nack,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic [7:0]        rd_reg,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        err_code
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_RD  = 8'h01;
  localparam logic [7:0] OP_WR  = 8'h02;
  localparam logic [7:0] OP_JMP = 8'h03;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_MEM  = 3'd1;
  localparam logic [2:0] E_OP   = 3'd2;
  localparam logic [2:0] E_NACK = 3'd3;
  localparam logic [2:0] E_TO   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_e;

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] pc_n;
  logic              valid_n, rw_n, rdv_n, busy_n, halted_n;
  logic [7:0]        dev_n, reg_n, wd_n, rdd_n, rdr_n;
  logic [2:0]        err_n;
  logic [7:0]        op;

  assign op = instr_data[31:24];

  // State and every output are registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      reg_addr      <= '0;
      i2c_req_valid <= 1'b0;
      i2c_req_rw    <= 1'b0;
      i2c_dev_addr  <= '0;
      i2c_reg_addr  <= '0;
      i2c_wdata     <= '0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      rd_reg        <= '0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      err_code      <= E_NONE;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      reg_addr      <= pc_n;
      i2c_req_valid <= valid_n;
      i2c_req_rw    <= rw_n;
      i2c_dev_addr  <= dev_n;
      i2c_reg_addr  <= reg_n;
      i2c_wdata     <= wd_n;
      rd_valid      <= rdv_n;
      rd_data       <= rdd_n;
      rd_reg        <= rdr_n;
      busy          <= busy_n;
      halted        <= halted_n;
      err_code      <= err_n;
    end
  end

  // Next state and next register values; everything holds by default.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = reg_addr;
    valid_n = i2c_req_valid;
    rw_n    = i2c_req_rw;
    dev_n   = i2c_dev_addr;
    reg_n   = i2c_reg_addr;
    wd_n    = i2c_wdata;
    rdv_n   = 1'b0;
    rdd_n   = rd_data;
    rdr_n   = rd_reg;
    err_n   = err_code;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_n    = '0;
          err_n   = E_NONE;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (mem_error != 4'h0) begin
          err_n   = E_MEM;
          state_n = S_HALT;
        end else begin
          unique case (1'b1)
            (op == OP_NOP): begin
              pc_n    = reg_addr + ADDR_W'(1);
              state_n = S_FETCH;
            end
            (op == OP_RD || op == OP_WR): begin
              rw_n    = (op == OP_RD);
              dev_n   = instr_data[23:16];
              reg_n   = instr_data[15:8];
              wd_n    = (op == OP_RD) ? 8'h00 : instr_data[7:0];
              valid_n = 1'b1;
              state_n = S_ISSUE;
            end
            (op == OP_JMP): begin
              pc_n    = instr_data[ADDR_W-1:0];
              state_n = S_FETCH;
            end
            default: begin
              err_n   = E_OP;
              state_n = S_HALT;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (i2c_req_ready) begin
          valid_n = 1'b0;
          cnt_n   = '0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i2c_done) begin
          if (i2c_nack) begin
            err_n   = E_NACK;
            state_n = S_HALT;
          end else begin
            if (i2c_req_rw) begin
              rdv_n = 1'b1;
              rdd_n = i2c_rdata;
              rdr_n = i2c_reg_addr;
            end
            pc_n    = reg_addr + ADDR_W'(1);
            state_n = S_FETCH;
          end
        end else if (cnt == CNT_LAST) begin
          err_n   = E_TO;
          state_n = S_HALT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n   = !(state_n == S_IDLE || state_n == S_HALT);
    halted_n = (state_n == S_HALT);
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: program table plus memory and I2C master models,
// with request and read-result scoreboards.
module tb_instruction_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  reg_addr;
  logic [31:0] instr_data = '0;
  logic [3:0]  mem_error = '0;
  logic        i2c_req_valid;
  logic        i2c_req_ready = 1'b0;
  logic        i2c_req_rw;
  logic [7:0]  i2c_dev_addr, i2c_reg_addr, i2c_wdata;
  logic        i2c_done = 1'b0;
  logic [7:0]  i2c_rdata = '0;
  logic        i2c_nack = 1'b0;
  logic        rd_valid;
  logic [7:0]  rd_data, rd_reg;
  logic        busy, halted;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  instruction_sequencer #(.ADDR_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .reg_addr(reg_addr), .instr_data(instr_data), .mem_error(mem_error),
    .i2c_req_valid(i2c_req_valid), .i2c_req_ready(i2c_req_ready),
    .i2c_req_rw(i2c_req_rw), .i2c_dev_addr(i2c_dev_addr),
    .i2c_reg_addr(i2c_reg_addr), .i2c_wdata(i2c_wdata),
    .i2c_done(i2c_done), .i2c_rdata(i2c_rdata), .i2c_nack(i2c_nack),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_reg(rd_reg),
    .busy(busy), .halted(halted), .err_code(err_code)
  );

  typedef struct {
    logic       rw;
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
  } req_t;

  typedef struct {
    logic [7:0] rg;
    logic [7:0] d;
  } rd_t;

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    int          len;
    int          stall;
    int          dly;
    bit          nack;
    logic [7:0]  rdata;
    logic [2:0]  err;
    logic [7:0]  pc;
  } test_t;

  req_t        sbq[$];
  rd_t         rdq[$];
  logic [31:0] prog [256];
  int          plen = 0;
  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          m_left = 0;
  int          m_dly = -1;
  int          m_wait = -1;
  bit          m_nack = 1'b0;
  logic [7:0]  m_rdata = '0;
  req_t        m_cur;
  bit          exp_rdv = 1'b0;
  int          hs_cyc = -1;
  int          halt_cyc = -1;
  test_t       tv[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_fields"},
        {i2c_dev_addr, i2c_reg_addr, i2c_wdata, reg_addr}, 32'h0);
    chk({nm, "_ctl"},
        {8'h0, rd_data, rd_reg, err_code, i2c_req_valid, i2c_req_rw,
         rd_valid, busy, halted}, 32'h0);
  endtask

  // Memory model, I2C master model and output monitors, all on negedge.
  initial begin
    m_cur = '{1'b0, 8'h0, 8'h0, 8'h0};
    forever begin
      @(negedge clk);
      cyc++;
      instr_data = prog[reg_addr];
      mem_error  = (int'(reg_addr) >= plen) ? 4'h1 : 4'h0;
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if (rd_valid || exp_rdv) begin
        chk("rd_valid", {31'h0, rd_valid}, {31'h0, exp_rdv});
        if (exp_rdv && rdq.size() > 0) begin
          chk("rd_data", {24'h0, rd_data}, {24'h0, rdq[0].d});
          chk("rd_reg", {24'h0, rd_reg}, {24'h0, rdq[0].rg});
          void'(rdq.pop_front());
        end
      end
      exp_rdv  = 1'b0;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (m_wait == 0) begin
        i2c_done  = 1'b1;
        i2c_nack  = m_nack;
        i2c_rdata = m_rdata;
        m_wait    = -1;
        if (m_cur.rw && !m_nack && m_dly < TO) begin
          exp_rdv = 1'b1;
          rdq.push_back('{m_cur.rg, m_rdata});
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end
      if (i2c_req_ready) begin
        i2c_req_ready = 1'b0;
        hs_cyc = cyc;
        chk("valid_drop", {31'h0, i2c_req_valid}, 32'h0);
        m_wait = (m_dly > 0) ? m_dly - 1 : -1;
      end else if (i2c_req_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_req", {31'h0, i2c_req_valid}, 32'h0);
        end else begin
          chk("req_fields",
              {7'h0, i2c_req_rw, i2c_dev_addr, i2c_reg_addr, i2c_wdata},
              {7'h0, sbq[0].rw, sbq[0].dev, sbq[0].rg, sbq[0].wd});
          if (m_left > 0) begin
            m_left--;
          end else begin
            m_cur = sbq.pop_front();
            i2c_req_ready = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_prog(input test_t t, input int idx);
    int pc;
    logic [31:0] w;
    repeat (3) @(negedge clk);
    sbq.delete();
    rdq.delete();
    prog[0] = t.i0;
    prog[1] = t.i1;
    plen    = t.len;
    m_left  = t.stall;
    m_dly   = t.dly;
    m_nack  = t.nack;
    m_rdata = t.rdata;
    m_wait  = -1;
    pc = 0;
    for (int s = 0; s < 8; s++) begin
      if (pc >= t.len) break;
      w = prog[pc];
      if (w[31:24] == 8'h00) begin
        pc++;
      end else if (w[31:24] == 8'h03) begin
        pc = int'(w[7:0]);
      end else if (w[31:24] == 8'h01 || w[31:24] == 8'h02) begin
        sbq.push_back('{w[31:24] == 8'h01, w[23:16], w[15:8],
                        (w[31:24] == 8'h01) ? 8'h00 : w[7:0]});
        if (t.nack || t.dly < 0 || t.dly >= TO) break;
        pc++;
      end else begin
        break;
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    halt_cyc = -1;
    hs_cyc = -1;
    for (int k = 0; k < 600 && !halted; k++) @(negedge clk);
    chk($sformatf("t%0d_halted", idx), {31'h0, halted}, 32'h1);
    chk($sformatf("t%0d_err", idx), {29'h0, err_code}, {29'h0, t.err});
    chk($sformatf("t%0d_pc", idx), {24'h0, reg_addr}, {24'h0, t.pc});
    chk($sformatf("t%0d_busy", idx), {31'h0, busy}, 32'h0);
    chk($sformatf("t%0d_reqs_left", idx), sbq.size(), 32'h0);
    chk($sformatf("t%0d_rds_left", idx), rdq.size(), 32'h0);
    if (t.err == 3'd4)
      chk($sformatf("t%0d_to_len", idx), halt_cyc - hs_cyc, TO);
  endtask

  initial begin
    tv[0]  = '{32'h011D0F00, 32'h021DAB32, 2, 0, 5, 1'b0, 8'h5A, 3'd1, 8'd2};
    tv[1]  = '{32'h07000000, 32'h0, 1, 0, 0, 1'b0, 8'h00, 3'd2, 8'd0};
    tv[2]  = '{32'h01220300, 32'h0, 1, 0, 4, 1'b1, 8'h11, 3'd3, 8'd0};
    tv[3]  = '{32'h01230400, 32'h0, 1, 0, -1, 1'b0, 8'h00, 3'd4, 8'd0};
    tv[4]  = '{32'h024455AA, 32'h0, 1, 20, 3, 1'b0, 8'h00, 3'd1, 8'd1};
    tv[5]  = '{32'hFF000000, 32'h0, 1, 0, 0, 1'b0, 8'h00, 3'd2, 8'd0};
    tv[6]  = '{32'h01010100, 32'h0, 0, 0, 0, 1'b0, 8'h00, 3'd1, 8'd0};
    tv[7]  = '{32'h03000002, 32'h0, 2, 0, 0, 1'b0, 8'h00, 3'd1, 8'd2};
    tv[8]  = '{32'h01316600, 32'h0, 1, 0, 14, 1'b0, 8'h77, 3'd1, 8'd1};
    tv[9]  = '{32'h01327700, 32'h0, 1, 0, 15, 1'b0, 8'h99, 3'd4, 8'd0};
    tv[10] = '{32'h02400001, 32'h0, 1, 0, 2, 1'b1, 8'h00, 3'd3, 8'd0};
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    prog[0] = 32'h00000000;
    prog[1] = 32'h03000000;
    plen = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("loop_pc%0d", k), {24'h0, reg_addr}, (k / 2) % 2);
      chk($sformatf("loop_busy%0d", k), {30'h0, busy, halted}, 32'h2);
      start = (k == 6);
      @(negedge clk);
    end
    start = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_zero("loop_rst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_prog(tv[i], i);

    repeat (3) @(negedge clk);
    sbq.delete();
    rdq.delete();
    prog[0] = 32'h01500100;
    plen    = 1;
    m_left  = 0;
    m_dly   = -1;
    m_nack  = 1'b0;
    m_wait  = -1;
    sbq.push_back('{1'b1, 8'h50, 8'h01, 8'h00});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs_cyc = -1;
    for (int k = 0; k < 50 && hs_cyc < 0; k++) @(negedge clk);
    chk("wait_reached", {31'h0, (hs_cyc >= 0)}, 32'h1);
    repeat (3) @(negedge clk);
    chk("wait_busy", {31'h0, busy}, 32'h1);
    #2 reset_n = 1'b0;
    #1 chk_zero("wait_rst");
    i2c_req_ready = 1'b0;
    m_wait = -1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
